// File: rtl/constants_pkg.sv
// Shared numeric constants for the hazard controller and its sequencer.
package constants_pkg;

    localparam int unsigned MUL_LATENCY_DEF = 3;
    localparam int unsigned DIV_LATENCY_DEF = 8;
    localparam int unsigned PERF_CNT_W_DEF  = 32;
    localparam int unsigned LAT_W           = 4;
    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned FUNC3_W         = 3;

endpackage

// File: rtl/structure_pkg.sv
// Pipeline payload types shared between decode and the hazard controller.
package structure_pkg;

    import constants_pkg::*;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] src_reg_1;
        logic [REG_ADDR_W-1:0] src_reg_2;
        logic [REG_ADDR_W-1:0] dst_reg;
        logic                  reg_write_enable;
        logic                  reg_data_ready;
        logic                  is_l;
        logic                  is_m;
        logic [FUNC3_W-1:0]    func3;
    } inst_decoded_t;

    typedef struct packed {
        logic dep_src1;
        logic dep_src2;
    } bypass_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hazard_state_e;

    // A producer matches a source when it will write that non-zero register.
    function automatic logic reg_match(input inst_decoded_t prod,
                                       input logic [REG_ADDR_W-1:0] src);
        return prod.valid & prod.reg_write_enable &
               (prod.dst_reg != '0) & (prod.dst_reg == src);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Latency-counter FSM holding a multi-cycle M-op in EXE; outputs are Mealy (combinational).
module muldiv_sequencer
    import constants_pkg::*;
    import structure_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic             mstall_c_o,
    output logic             muldiv_done_c_o
);

    hazard_state_e    state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt holds the remaining stalled-or-done cycles after the start cycle.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        mstall_c_o      = 1'b0;
        muldiv_done_c_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (lat_i > LAT_W'(1)) begin
                        mstall_c_o = 1'b1;
                        state_d    = BUSY;
                        cnt_d      = lat_i - LAT_W'(1);
                    end else begin
                        muldiv_done_c_o = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q > LAT_W'(1)) begin
                    mstall_c_o = 1'b1;
                    cnt_d      = cnt_q - LAT_W'(1);
                end else begin
                    muldiv_done_c_o = 1'b1;
                    cnt_d           = '0;
                    state_d         = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_controller.sv
// Forwarding selects, load-use bubble and M-op stall scheduling for the 5-stage pipeline.
// Optional perf counters: define HAZARD_CTRL_PERF_CNT_EN.
module hazard_controller
    import constants_pkg::*;
    import structure_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEF,
    parameter int unsigned PERF_CNT_W  = PERF_CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  inst_decoded_t inst_dec_in,
    input  inst_decoded_t inst_exe_in,
    input  inst_decoded_t inst_mem_in,
    output bypass_t       exe_bypass,
    output bypass_t       mem_bypass,
    output logic          load_to_use_hazard,
    output logic          stall_fetch,
    output logic          stall_decode,
    output logic          stall_exe,
    output logic          muldiv_done
`ifdef HAZARD_CTRL_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_lu_cnt,
    output logic [PERF_CNT_W-1:0] perf_mstall_cnt,
    output logic [PERF_CNT_W-1:0] perf_fwd_cnt
`endif
);

    localparam logic [LAT_W-1:0] MUL_LAT = LAT_W'(MUL_LATENCY);
    localparam logic [LAT_W-1:0] DIV_LAT = LAT_W'(DIV_LATENCY);

    logic             hit_exe_1_c, hit_exe_2_c;
    logic             hit_mem_1_c, hit_mem_2_c;
    logic             lu_c;
    logic             start_c;
    logic [LAT_W-1:0] lat_c;
    logic             mstall_c;
    logic             done_c;
    logic             unused_inputs_c;

    // Youngest ready producer wins; MEM only forwards when EXE does not.
    always_comb begin
        hit_exe_1_c = reg_match(inst_exe_in, inst_dec_in.src_reg_1);
        hit_exe_2_c = reg_match(inst_exe_in, inst_dec_in.src_reg_2);
        hit_mem_1_c = reg_match(inst_mem_in, inst_dec_in.src_reg_1);
        hit_mem_2_c = reg_match(inst_mem_in, inst_dec_in.src_reg_2);

        exe_bypass          = '0;
        exe_bypass.dep_src1 = hit_exe_1_c & inst_exe_in.reg_data_ready;
        exe_bypass.dep_src2 = hit_exe_2_c & inst_exe_in.reg_data_ready;

        mem_bypass          = '0;
        mem_bypass.dep_src1 = hit_mem_1_c & inst_mem_in.reg_data_ready & ~exe_bypass.dep_src1;
        mem_bypass.dep_src2 = hit_mem_2_c & inst_mem_in.reg_data_ready & ~exe_bypass.dep_src2;

        lu_c    = inst_dec_in.valid & inst_exe_in.is_l & (hit_exe_1_c | hit_exe_2_c);
        start_c = inst_exe_in.valid & inst_exe_in.is_m;
        lat_c   = inst_exe_in.func3[2] ? DIV_LAT : MUL_LAT;
    end

    // The sequencer only honours start while idle, so a held M-op never restarts.
    muldiv_sequencer u_muldiv_sequencer (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_c),
        .lat_i           (lat_c),
        .mstall_c_o      (mstall_c),
        .muldiv_done_c_o (done_c)
    );

    assign stall_exe          = mstall_c;
    assign stall_fetch        = mstall_c | lu_c;
    assign stall_decode       = mstall_c | lu_c;
    assign load_to_use_hazard = lu_c & ~mstall_c;
    assign muldiv_done        = done_c;

    assign unused_inputs_c = ^{inst_dec_in, inst_exe_in, inst_mem_in};

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] perf_lu_q, perf_lu_d;
    logic [PERF_CNT_W-1:0] perf_mstall_q, perf_mstall_d;
    logic [PERF_CNT_W-1:0] perf_fwd_q, perf_fwd_d;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v,
                                                      input logic inc);
        return (inc && (v != '1)) ? v + PERF_CNT_W'(1) : v;
    endfunction

    always_comb begin
        perf_lu_d     = sat_inc(perf_lu_q, load_to_use_hazard);
        perf_mstall_d = sat_inc(perf_mstall_q, stall_exe);
        perf_fwd_d    = sat_inc(perf_fwd_q, |{exe_bypass, mem_bypass});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lu_q     <= '0;
            perf_mstall_q <= '0;
            perf_fwd_q    <= '0;
        end else begin
            perf_lu_q     <= perf_lu_d;
            perf_mstall_q <= perf_mstall_d;
            perf_fwd_q    <= perf_fwd_d;
        end
    end

    assign perf_lu_cnt     = perf_lu_q;
    assign perf_mstall_cnt = perf_mstall_q;
    assign perf_fwd_cnt    = perf_fwd_q;
`else
    localparam int unsigned unused_perf_cnt_w = PERF_CNT_W;
`endif

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Central hazard and stall scheduler for the 5-stage pipeline.
- Compares the instruction leaving decode against the instructions in EXE and MEM.
- Drives the bypass selects consumed by decode_stage.
- Drives the load-to-use bubble.
- Sequences multi-cycle M-extension (MUL/DIV) occupancy of EXE with a latency counter FSM, freezing fetch/decode/EXE until the result is ready.

Parameters:
MUL_LATENCY, 3, total cycles a MUL* (func3[2]=0) occupies EXE; legal range 1..15
DIV_LATENCY, 8, total cycles a DIV*/REM* (func3[2]=1) occupies EXE; legal range 1..15
PERF_CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
inst_dec_in  in  inst_decoded_t  combinational decode_stage output (src_reg_1/2, valid)
inst_exe_in  in  inst_decoded_t  instruction currently in EXE
inst_mem_in  in  inst_decoded_t  instruction currently in MEM
exe_bypass  out  bypass_t  dep_src1/dep_src2: forward from EXE
mem_bypass  out  bypass_t  dep_src1/dep_src2: forward from MEM
load_to_use_hazard  out  1  decode emits bubble into EXE this cycle
stall_fetch  out  1  hold PC and fetch register
stall_decode  out  1  hold decode input register
stall_exe  out  1  hold EXE register (M-op not finished)
muldiv_done  out  1  M-op result valid in EXE this cycle

Behaviour:
- Reset: async on rst=0; state=IDLE, cnt=0. All outputs are 0 while in reset, since exe/mem match terms are gated by input valid bits and drivers hold them low.
- Match term, per source s in {1,2} and stage X in {exe,mem}:
  - hitX_s = X.valid & X.reg_write_enable & X.dst_reg!=0 & X.dst_reg==dec.src_reg_s.
  - x0 is never forwarded.
  - I-type src2 is already 0 from decode, so it never matches.
- Bypass (combinational):
  - exe_bypass.dep_src_s = hitEXE_s & exe.reg_data_ready.
  - mem_bypass.dep_src_s = hitMEM_s & mem.reg_data_ready & ~exe_bypass.dep_src_s.
  - The youngest producer wins; the two selects are never both set for one source.
- Load-use: lu = dec.valid & exe.is_l & (hitEXE_1 | hitEXE_2).
- M-op start: start = exe.valid & exe.is_m & (state==IDLE). lat = func3[2] ? DIV_LATENCY : MUL_LATENCY.
- FSM, states IDLE and BUSY, with a 4-bit counter cnt:
  - IDLE, start & lat>1: mstall=1; next state BUSY; cnt<=lat-1.
  - IDLE, start & lat==1: mstall=0; muldiv_done=1; stay IDLE.
  - IDLE, no start: mstall=0.
  - BUSY, cnt>1: mstall=1; cnt<=cnt-1.
  - BUSY, cnt==1: mstall=0; muldiv_done=1; cnt<=0; next state IDLE.
  - The M-op therefore occupies EXE for exactly lat cycles and is stalled for lat-1 of them.
- Outputs:
  - stall_exe = mstall.
  - stall_fetch = stall_decode = mstall | lu.
  - load_to_use_hazard = lu & ~mstall. While EXE is frozen, no bubble is inserted; the hazard re-evaluates after release.
- Simultaneous events: when lu and mstall are both active, stall wins. The load is not in EXE during BUSY, so lu only coexists with an IDLE start when the M-op is the producer; is_l=0 then, so lu=0 there.
- Back-to-back M-ops: the cycle after done, state is IDLE and the new EXE occupant may start immediately.
- Reset mid-BUSY: returns to IDLE immediately; the pipeline is flushed by the global reset.
- No register on the bypass/lu path: zero-cycle latency from inputs.

Optional Feature:
Macro HAZARD_CTRL_PERF_CNT_EN.
- With the macro, three outputs are added, each PERF_CNT_W bits, saturating, reset to 0:
  - perf_lu_cnt: +1 per cycle with load_to_use_hazard=1.
  - perf_mstall_cnt: +1 per cycle with stall_exe=1.
  - perf_fwd_cnt: +1 per cycle with any bypass bit set.
- Without the macro, these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- structure_pkg: reuse inst_decoded_t and bypass_t unchanged; add hazard_state_e {IDLE, BUSY}.
- constants_pkg: MUL_LATENCY_DEF, DIV_LATENCY_DEF.
- Sub-module muldiv_sequencer holds the FSM and counter (inputs: start, lat; outputs: mstall, muldiv_done). Forwarding and load-use logic stay in the top level.

Test Plan:
- Forward priority: EXE ADD x5 (ready), MEM ADD x5 (ready), decode src1=x5 → exe_bypass.dep_src1=1, mem_bypass.dep_src1=0.
- x0 and invalid producer: EXE writes x0, decode src1=x0 → no bypass. EXE valid=0 with dst=x3, decode src2=x3 → no bypass.
- Load-use: EXE LW x7 (is_l, ready=0), decode src2=x7 → load_to_use_hazard=1, stall_fetch=stall_decode=1, for 1 cycle. Next cycle, LW in MEM with ready=1 → mem_bypass.dep_src2=1 and the stall drops.
- MUL with MUL_LATENCY=3: stall_exe=1,1,0 over 3 cycles; muldiv_done=1 in cycle 3 only. DIV with DIV_LATENCY=8: 7 stall cycles, then done.
- Back-to-back MUL, MUL: second starts the cycle after first done → 2 stall cycles each; no lost or extra cycle. Also with MUL_LATENCY=1: no stall, done the same cycle.
- Assert rst=0 in BUSY cnt=4 → all outputs 0 asynchronously; after release, state=IDLE. With HAZARD_CTRL_PERF_CNT_EN: 3-cycle MUL gives perf_mstall_cnt=2.
